fp_div_seq_ctrl: RTL and testbench

Sequenced single-precision (IEEE-754 binary32) divider with a valid/ready handshake on both sides. An FSM controls a radix-2 restoring mantissa divider, the exponent/sign path, the special-case bypass and result normalization. It sits between the FPU issue logic and the result writeback, and replaces single-cycle combinational division with a fixed-latency multi-cycle operation. Rounding is truncation (round toward zero). Denormal operands flush to zero.

---
 rtl/fp_div_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_fp_div_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq_ctrl.sv
// Sequenced binary32 divider: radix-2 restoring mantissa loop,
// special-case bypass, truncating normalization, valid/ready on both sides.
module fp_div_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        busy
);

  localparam int ITER = 26;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // flag bit positions inside {invalid, div_by_zero, overflow, underflow}
  localparam logic [3:0] F_INV = 4'b1000;
  localparam logic [3:0] F_DBZ = 4'b0100;
  localparam logic [3:0] F_OVF = 4'b0010;
  localparam logic [3:0] F_UNF = 4'b0001;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] rem_q, rem_d;
  logic [25:0] quo_q, quo_d;
  logic [23:0] mb_q, mb_d;
  logic        sign_q, sign_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        out_valid_q, out_valid_d;

  // operand classification, evaluated on the live inputs at accept
  logic [7:0] a_exp;
  logic [7:0] b_exp;
  logic       a_zero;
  logic       b_zero;
  logic       any_inf_nan;
  logic       in_sign;
  logic       accept;

  assign a_exp       = a[30:23];
  assign b_exp       = b[30:23];
  assign a_zero      = (a_exp == 8'd0);
  assign b_zero      = (b_exp == 8'd0);
  assign any_inf_nan = (a_exp == 8'hFF) || (b_exp == 8'hFF);
  assign in_sign     = a[31] ^ b[31];

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // one restoring step: subtract when it fits, then shift
  logic        qbit;
  logic [24:0] mb_ext;
  logic [24:0] rem_sub;

  assign mb_ext  = {1'b0, mb_q};
  assign qbit    = (rem_q >= mb_ext);
  assign rem_sub = qbit ? (rem_q - mb_ext) : rem_q;

  // exponent and mantissa selection for normalization
  logic signed [9:0] e_raw;
  logic signed [9:0] e_fin;
  logic [22:0]       mant;

  assign e_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
               + 10'sd127;
  assign e_fin = quo_q[25] ? e_raw : (e_raw - 10'sd1);
  assign mant  = quo_q[25] ? quo_q[24:2] : quo_q[23:1];

  // next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    mb_d        = mb_q;
    sign_d      = sign_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sign_d = in_sign;
          ea_d   = a_exp;
          eb_d   = b_exp;
          rem_d  = {2'b01, a[22:0]};
          mb_d   = {1'b1, b[22:0]};
          quo_d  = '0;
          cnt_d  = '0;
          if (any_inf_nan || (a_zero && b_zero)) begin
            result_d    = QNAN;
            flags_d     = F_INV;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (b_zero) begin
            result_d    = {in_sign, 8'hFF, 23'd0};
            flags_d     = F_DBZ;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (a_zero) begin
            result_d    = {in_sign, 31'd0};
            flags_d     = 4'b0000;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_ITER;
          end
        end
      end

      S_ITER: begin
        rem_d = rem_sub << 1;
        quo_d = {quo_q[24:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (e_fin >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          flags_d  = F_OVF;
        end else if (e_fin <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          flags_d  = F_UNF;
        end else begin
          result_d = {sign_q, e_fin[7:0], mant};
          flags_d  = 4'b0000;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      mb_q        <= '0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      mb_q        <= mb_d;
      sign_q      <= sign_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign busy      = (state_q == S_ITER) || (state_q == S_NORM);

endmodule

// File: tb/tb_fp_div_seq_ctrl.sv
// Scoreboard bench for fp_div_seq_ctrl: directed cases, specials,
// range limits, backpressure, mid-operation reset and random operands.
module tb_fp_div_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        busy;

  fp_div_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e0_cyc = 0;
  logic ov_prev = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: integer long division of the scaled mantissas
  function automatic exp_t model(input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t r;
    logic       s;
    int         ex;
    int         ey;
    int         e;
    logic [63:0] num;
    logic [63:0] q;
    logic [22:0] m;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    r.fl  = 4'b0000;
    r.lat = 0;
    if (ex == 255 || ey == 255 || (ex == 0 && ey == 0)) begin
      r.res = 32'h7FC00000;
      r.fl  = 4'b1000;
    end else if (ey == 0) begin
      r.res = {s, 8'hFF, 23'd0};
      r.fl  = 4'b0100;
    end else if (ex == 0) begin
      r.res = {s, 31'd0};
    end else begin
      r.lat = 27;
      num = {40'd0, 1'b1, x[22:0]} << 25;
      q   = num / {40'd0, 1'b1, y[22:0]};
      e   = ex - ey + 127;
      if (q[25]) begin
        m = q[24:2];
      end else begin
        m = q[23:1];
        e = e - 1;
      end
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'd0};
        r.fl  = 4'b0010;
      end else if (e <= 0) begin
        r.res = {s, 31'd0};
        r.fl  = 4'b0001;
      end else begin
        r.res = {s, 8'(e), m};
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // output monitor: latency on rising out_valid, data at handshake
  always @(negedge clk) begin
    exp_t ex;
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        if (sbq.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - e0_cyc), 64'(sbq[0].lat));
      end
      if (out_valid && out_ready && sbq.size() > 0) begin
        ex = sbq.pop_front();
        chk("result", {32'd0, result}, {32'd0, ex.res});
        chk("flags", {60'd0, flags}, {60'd0, ex.fl});
      end
    end
    ov_prev = out_valid;
  end

  task automatic issue(input logic [31:0] x,
                       input logic [31:0] y,
                       input bit push);
    int n;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) sbq.push_back(model(x, y));
    @(posedge clk);
    #1;
    e0_cyc   = cyc;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  logic [31:0] r_hold;
  logic [3:0]  f_hold;

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_flags", {60'd0, flags}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // 6.0 / 2.0 with busy window
    issue(32'h40C00000, 32'h40000000, 1'b1);
    repeat (27) begin
      @(negedge clk);
      chk("busy_hi", {63'd0, busy}, 64'd1);
    end
    @(negedge clk);
    chk("busy_lo", {63'd0, busy}, 64'd0);
    chk("r_6_2", {32'd0, result}, 64'h40400000);

    issue(32'h3F800000, 32'h40400000, 1'b1);
    drain();
    chk("r_1_3", {32'd0, result}, 64'h3EAAAAAA);

    // specials back to back
    issue(32'hC1000000, 32'h00000000, 1'b1);
    issue(32'h00000000, 32'h00000000, 1'b1);
    issue(32'h7F800000, 32'h3F800000, 1'b1);
    issue(32'h00000000, 32'h40000000, 1'b1);
    issue(32'h7F000000, 32'h00800000, 1'b1);
    issue(32'h00800000, 32'h7F000000, 1'b1);
    drain();
    chk("r_unf", {32'd0, result}, 64'h00000000);

    // backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(32'hC0C00000, 32'h40000000, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", {63'd0, out_valid}, 64'd1);
    r_hold = result;
    f_hold = flags;
    chk("bp_result", {32'd0, r_hold}, 64'hC0400000);
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      chk("bp_hold_res", {32'd0, result}, {32'd0, r_hold});
      chk("bp_hold_flg", {60'd0, flags}, {60'd0, f_hold});
      chk("bp_hold_ov", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_rdy", {63'd0, in_ready}, 64'd1);
    issue(32'h3F800000, 32'h40400000, 1'b1);
    drain();

    // reset in the middle of ITER
    issue(32'h40C00000, 32'h40000000, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdy", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", {63'd0, in_ready}, 64'd1);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_ov", {63'd0, out_valid}, 64'd0);
    repeat (30) @(negedge clk);
    issue(32'h40C00000, 32'h40000000, 1'b1);
    drain();
    chk("r_after_rst", {32'd0, result}, 64'h40400000);

    // random operands, normal-range and unconstrained
    for (int i = 0; i < 8; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
      y = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
      issue(x, y, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      issue($urandom, $urandom, 1'b1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
